// File: rtl/cvw_arch_verif_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cvw_arch_verif_monitor
// Function : RVVI single-retire functional-coverage monitor (counters, hit
//            bitmaps, sticky trace-consistency flags). Optional FP register
//            coverage when COVER_FP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module cvw_arch_verif_monitor #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [63:0]      order,
    input  logic [31:0]      insn,
    input  logic             trap,
    input  logic             debug_mode,
    input  logic [XLEN-1:0]  pc_rdata,
    input  logic [1:0]       mode,
    input  logic             m_ext_intr,
    input  logic             s_ext_intr,
    input  logic             m_timer_intr,
    input  logic             m_soft_intr,
    input  logic [31:0]      x_wb,
    input  logic [31:0]      f_wb,
    input  logic             csr_wb,
    input  logic [11:0]      csr_addr,
    input  logic             clear,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] trap_cnt,
    output logic [CNT_W-1:0] intr_cnt,
    output logic [CNT_W-1:0] csr_wr_cnt,
    output logic [31:0]      opcode_hit,
    output logic [2:0]       c_quad_hit,
    output logic [3:0]       mode_hit,
    output logic [31:0]      xrd_hit,
    output logic [31:0]      frd_hit,
    output logic             csr_mstatus_hit,
    output logic             order_err,
    output logic             pc_err,
    output logic             mode_err
);

    localparam logic [11:0]      C_MSTATUS = 12'h300;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] retired_q, retired_d, trap_q, trap_d;
    logic [CNT_W-1:0] intr_q, intr_d, csr_q, csr_d;
    logic [31:0]      opcode_q, opcode_d, xrd_q, xrd_d;
    logic [2:0]       cquad_q, cquad_d;
    logic [3:0]       mode_q, mode_d;
    logic             mst_q, mst_d, oerr_q, oerr_d, perr_q, perr_d, merr_q, merr_d;
    logic             seen_q, seen_d;
    logic [63:0]      prev_order_q, prev_order_d;
    logic             w_any_intr;
    logic             w_cover;
    logic             w_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + C_CNT_ONE;
    endfunction

    assign w_any_intr = m_ext_intr | s_ext_intr | m_timer_intr | m_soft_intr;
    assign w_cover    = valid & ~trap & ~debug_mode;

    always_comb begin
        retired_d    = retired_q;
        trap_d       = trap_q;
        intr_d       = intr_q;
        csr_d        = csr_q;
        opcode_d     = opcode_q;
        xrd_d        = xrd_q;
        cquad_d      = cquad_q;
        mode_d       = mode_q;
        mst_d        = mst_q;
        oerr_d       = oerr_q;
        perr_d       = perr_q;
        merr_d       = merr_q;
        seen_d       = seen_q;
        prev_order_d = prev_order_q;
        if (clear) begin
            // A sample arriving alongside clear is dropped entirely.
            retired_d    = '0;
            trap_d       = '0;
            intr_d       = '0;
            csr_d        = '0;
            opcode_d     = '0;
            xrd_d        = '0;
            cquad_d      = '0;
            mode_d       = '0;
            mst_d        = 1'b0;
            oerr_d       = 1'b0;
            perr_d       = 1'b0;
            merr_d       = 1'b0;
            seen_d       = 1'b0;
            prev_order_d = '0;
        end else if (valid) begin
            mode_d = mode_q | (4'b0001 << mode);
            if (mode == 2'd2)   merr_d = 1'b1;
            if (pc_rdata[0])    perr_d = 1'b1;
            if (seen_q && (order != prev_order_q + 64'd1)) oerr_d = 1'b1;
            seen_d       = 1'b1;
            prev_order_d = order;
            if (trap) begin
                trap_d = sat_inc(trap_q);
                if (w_any_intr) intr_d = sat_inc(intr_q);
            end else begin
                retired_d = sat_inc(retired_q);
                if (!debug_mode) begin
                    if (insn[1:0] == 2'b11) opcode_d = opcode_q | (32'd1 << insn[6:2]);
                    else                    cquad_d  = cquad_q | (3'b001 << insn[1:0]);
                    xrd_d = xrd_q | x_wb;
                    if (csr_wb) begin
                        csr_d = sat_inc(csr_q);
                        if (csr_addr == C_MSTATUS) mst_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q    <= '0;
            trap_q       <= '0;
            intr_q       <= '0;
            csr_q        <= '0;
            opcode_q     <= '0;
            xrd_q        <= '0;
            cquad_q      <= '0;
            mode_q       <= '0;
            mst_q        <= 1'b0;
            oerr_q       <= 1'b0;
            perr_q       <= 1'b0;
            merr_q       <= 1'b0;
            seen_q       <= 1'b0;
            prev_order_q <= '0;
        end else begin
            retired_q    <= retired_d;
            trap_q       <= trap_d;
            intr_q       <= intr_d;
            csr_q        <= csr_d;
            opcode_q     <= opcode_d;
            xrd_q        <= xrd_d;
            cquad_q      <= cquad_d;
            mode_q       <= mode_d;
            mst_q        <= mst_d;
            oerr_q       <= oerr_d;
            perr_q       <= perr_d;
            merr_q       <= merr_d;
            seen_q       <= seen_d;
            prev_order_q <= prev_order_d;
        end
    end

`ifdef COVER_FP_EN
    logic [31:0] frd_q, frd_d;

    always_comb begin
        frd_d = frd_q;
        if (clear)        frd_d = '0;
        else if (w_cover) frd_d = frd_q | f_wb;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frd_q <= '0;
        else          frd_q <= frd_d;
    end

    assign frd_hit  = frd_q;
    assign w_unused = ^{insn[31:7], pc_rdata[XLEN-1:1]};
`else
    assign frd_hit  = '0;
    assign w_unused = ^{insn[31:7], pc_rdata[XLEN-1:1], f_wb, w_cover};
`endif

    assign retired_cnt     = retired_q;
    assign trap_cnt        = trap_q;
    assign intr_cnt        = intr_q;
    assign csr_wr_cnt      = csr_q;
    assign opcode_hit      = opcode_q;
    assign c_quad_hit      = cquad_q;
    assign mode_hit        = mode_q;
    assign xrd_hit         = xrd_q;
    assign csr_mstatus_hit = mst_q;
    assign order_err       = oerr_q;
    assign pc_err          = perr_q;
    assign mode_err        = merr_q;

endmodule
`default_nettype wire

// File: tb/tb_cvw_arch_verif_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvw_arch_verif_monitor
// Function : Table-driven scoreboard bench for cvw_arch_verif_monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_cvw_arch_verif_monitor;

    localparam int XLEN = 64;
    localparam int CW   = 4;
`ifdef COVER_FP_EN
    localparam logic [31:0] FPE = 32'h1;
`else
    localparam logic [31:0] FPE = 32'h0;
`endif
    localparam logic [63:0] P0 = 64'h8000_0000;
    localparam logic [63:0] P1 = 64'h8000_0001;

    typedef struct {
        logic [CW-1:0] ret, trp, itr, csr;
        logic [31:0]   op;
        logic [2:0]    cq;
        logic [3:0]    mh;
        logic [31:0]   xrd, frd;
        logic          mst, oe, pe, me;
    } exp_t;

    typedef struct {
        logic        clr, vld, trp, dbg;
        logic [63:0] ord;
        logic [31:0] insn;
        logic [63:0] pc;
        logic [1:0]  mode;
        logic [3:0]  intr;
        logic [31:0] xwb, fwb;
        logic        cwb;
        logic [11:0] caddr;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0, reset_n = 1'b0;
    logic valid = 1'b0, trap = 1'b0, debug_mode = 1'b0, csr_wb = 1'b0, clear = 1'b0;
    logic [63:0] order = '0;
    logic [31:0] insn = '0, x_wb = '0, f_wb = '0;
    logic [XLEN-1:0] pc_rdata = '0;
    logic [1:0] mode = '0;
    logic m_ext_intr = 1'b0, s_ext_intr = 1'b0, m_timer_intr = 1'b0, m_soft_intr = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [CW-1:0] retired_cnt, trap_cnt, intr_cnt, csr_wr_cnt;
    logic [31:0] opcode_hit, xrd_hit, frd_hit;
    logic [2:0] c_quad_hit;
    logic [3:0] mode_hit;
    logic csr_mstatus_hit, order_err, pc_err, mode_err;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];
    vec_t vt[16];

    always #5 clk = ~clk;

    cvw_arch_verif_monitor #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .order(order), .insn(insn),
        .trap(trap), .debug_mode(debug_mode), .pc_rdata(pc_rdata), .mode(mode),
        .m_ext_intr(m_ext_intr), .s_ext_intr(s_ext_intr), .m_timer_intr(m_timer_intr),
        .m_soft_intr(m_soft_intr), .x_wb(x_wb), .f_wb(f_wb), .csr_wb(csr_wb),
        .csr_addr(csr_addr), .clear(clear), .retired_cnt(retired_cnt),
        .trap_cnt(trap_cnt), .intr_cnt(intr_cnt), .csr_wr_cnt(csr_wr_cnt),
        .opcode_hit(opcode_hit), .c_quad_hit(c_quad_hit), .mode_hit(mode_hit),
        .xrd_hit(xrd_hit), .frd_hit(frd_hit), .csr_mstatus_hit(csr_mstatus_hit),
        .order_err(order_err), .pc_err(pc_err), .mode_err(mode_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, ".retired"}, 64'(retired_cnt), 64'(e.ret));
        chk({tag, ".trap"},    64'(trap_cnt),    64'(e.trp));
        chk({tag, ".intr"},    64'(intr_cnt),    64'(e.itr));
        chk({tag, ".csrwr"},   64'(csr_wr_cnt),  64'(e.csr));
        chk({tag, ".opcode"},  64'(opcode_hit),  64'(e.op));
        chk({tag, ".cquad"},   64'(c_quad_hit),  64'(e.cq));
        chk({tag, ".mode"},    64'(mode_hit),    64'(e.mh));
        chk({tag, ".xrd"},     64'(xrd_hit),     64'(e.xrd));
        chk({tag, ".frd"},     64'(frd_hit),     64'(e.frd));
        chk({tag, ".mstatus"}, 64'(csr_mstatus_hit), 64'(e.mst));
        chk({tag, ".order_err"}, 64'(order_err), 64'(e.oe));
        chk({tag, ".pc_err"},  64'(pc_err),      64'(e.pe));
        chk({tag, ".mode_err"}, 64'(mode_err),   64'(e.me));
    endtask

    task automatic drive(input vec_t v);
        clear = v.clr; valid = v.vld; trap = v.trp; debug_mode = v.dbg;
        order = v.ord; insn = v.insn; pc_rdata = v.pc; mode = v.mode;
        {m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr} = v.intr;
        x_wb = v.xwb; f_wb = v.fwb; csr_wb = v.cwb; csr_addr = v.caddr;
    endtask

    // Plain retiring sample of addi in M-mode, one cycle long.
    task automatic samp(input logic [63:0] ord);
        @(negedge clk);
        clear = 1'b0; valid = 1'b1; trap = 1'b0; debug_mode = 1'b0; order = ord;
        insn = 32'h13; pc_rdata = P0; mode = 2'd3; x_wb = '0; f_wb = '0; csr_wb = 1'b0;
        {m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr} = 4'b0;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    initial begin
        exp_t z;
        exp_t e;
        z = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0};

        //             clr vld trp dbg ord  insn        pc  md intr  xwb          fwb    cwb caddr    ret trp itr csr op            cq      mh      xrd          frd  mst oe pe me
        vt[0]  = '{0,1,0,0, 64'd1,  32'h13, P0, 3, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{1, 0,0,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,0,0,0}};
        vt[1]  = '{0,1,0,0, 64'd2,  32'h13, P0, 3, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{2, 0,0,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,0,0,0}};
        vt[2]  = '{0,1,0,0, 64'd3,  32'h13, P0, 3, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{3, 0,0,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,0,0,0}};
        vt[3]  = '{0,1,0,0, 64'd5,  32'h13, P0, 3, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{4, 0,0,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,1,0,0}};
        vt[4]  = '{0,1,0,0, 64'd6,  32'h13, P0, 3, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{5, 0,0,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,1,0,0}};
        vt[5]  = '{0,1,1,0, 64'd7,  32'h33, P0, 3, 4'b0010, 32'h1, 32'h1, 1, 12'h300, '{5, 1,1,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,1,0,0}};
        vt[6]  = '{0,1,1,0, 64'd8,  32'h13, P0, 3, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{5, 2,1,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,1,0,0}};
        vt[7]  = '{0,0,0,0, 64'd99, 32'h33, P1, 2, 4'b1111, 32'hFFFF, 32'hF, 1, 12'h300, '{5, 2,1,0, 32'h10, 3'b000, 4'b1000, 32'h0, 32'h0, 0,1,0,0}};
        vt[8]  = '{0,1,0,0, 64'd9,  32'h01, P0, 3, 4'b0000, 32'h400, 32'h1, 0, 12'h0, '{6, 2,1,0, 32'h10, 3'b010, 4'b1000, 32'h400, FPE, 0,1,0,0}};
        vt[9]  = '{0,1,0,0, 64'd10, 32'h73, P0, 3, 4'b0000, 32'h0, 32'h0, 1, 12'h300, '{7, 2,1,1, 32'h1000_0010, 3'b010, 4'b1000, 32'h400, FPE, 1,1,0,0}};
        vt[10] = '{0,1,0,1, 64'd11, 32'h33, P0, 3, 4'b0000, 32'hF, 32'h2, 1, 12'h305,  '{8, 2,1,1, 32'h1000_0010, 3'b010, 4'b1000, 32'h400, FPE, 1,1,0,0}};
        vt[11] = '{0,1,0,0, 64'd12, 32'h02, P0, 1, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{9, 2,1,1, 32'h1000_0010, 3'b110, 4'b1010, 32'h400, FPE, 1,1,0,0}};
        vt[12] = '{0,1,0,0, 64'd13, 32'h13, P1, 2, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{10,2,1,1, 32'h1000_0010, 3'b110, 4'b1110, 32'h400, FPE, 1,1,1,1}};
        vt[13] = '{1,1,1,0, 64'd14, 32'h13, P1, 2, 4'b1111, 32'hFF, 32'hFF, 1, 12'h300, '{0, 0,0,0, 32'h0, 3'b000, 4'b0000, 32'h0, 32'h0, 0,0,0,0}};
        vt[14] = '{0,1,0,0, 64'd50, 32'h13, P0, 0, 4'b0000, 32'h0, 32'h0, 0, 12'h0,   '{1, 0,0,0, 32'h10, 3'b000, 4'b0001, 32'h0, 32'h0, 0,0,0,0}};
        vt[15] = '{0,1,1,0, 64'd51, 32'h13, P0, 0, 4'b0001, 32'h0, 32'h0, 0, 12'h0,   '{1, 1,1,0, 32'h10, 3'b000, 4'b0001, 32'h0, 32'h0, 0,0,0,0}};

        repeat (2) @(posedge clk);
        #1 cmp_all("reset", z);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vt[i]);
            sb.push_back(vt[i].e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                cmp_all($sformatf("v%0d", i), e);
            end
        end
        valid = 1'b0;

        // Asynchronous reset mid-cycle, then restart at an unrelated order value.
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        chk("async_rst.retired", 64'(retired_cnt), 64'd0);
        chk("async_rst.mode_hit", 64'(mode_hit), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        samp(64'd1000);
        chk("post_rst.order_err", 64'(order_err), 64'd0);
        chk("post_rst.retired", 64'(retired_cnt), 64'd1);

        // Order sequence number wraps modulo 2^64 without error.
        samp(64'hFFFF_FFFF_FFFF_FFFE);
        chk("jump.order_err", 64'(order_err), 64'd1);
        @(negedge clk) clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        samp(64'hFFFF_FFFF_FFFF_FFFF);
        samp(64'd0);
        chk("wrap.order_err", 64'(order_err), 64'd0);
        chk("wrap.retired", 64'(retired_cnt), 64'd2);

        // Counters saturate at all-ones.
        for (int k = 1; k <= 20; k++) samp(64'(k));
        chk("sat.retired", 64'(retired_cnt), 64'hF);
        chk("sat.order_err", 64'(order_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cvw_arch_verif_monitor.md
# cvw_arch_verif_monitor

Synthesizable functional-coverage monitor that observes a single-hart, single-retire RVVI retirement trace. It accumulates retirement, trap and interrupt counters, hit bitmaps for opcodes, modes and written registers, and sticky trace-consistency error flags. It sits on the RVVI trace bus beside the architectural-verification bench and is read out directly through its output ports.

## Interface
- XLEN, 64, integer register and PC width (32 or 64)
- CNT_W, 32, width of every event counter
- clk  in  1  sampling clock; all activity is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid  in  1  trace sample is present this cycle
- order  in  64  instruction sequence number
- insn  in  32  instruction encoding (compressed encodings sit in [15:0])
- trap  in  1  instruction trapped and did not retire
- debug_mode  in  1  hart is in debug mode
- pc_rdata  in  XLEN  PC of the sampled instruction
- mode  in  2  privilege mode (0=U, 1=S, 3=M)
- m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr  in  1 each  pending-interrupt indications
- x_wb  in  32  integer register write mask
- f_wb  in  32  FP register write mask (used only with COVER_FP_EN)
- csr_wb  in  1  a CSR was written
- csr_addr  in  12  address of the CSR written
- clear  in  1  synchronous clear of all state
- retired_cnt, trap_cnt, intr_cnt, csr_wr_cnt  out  CNT_W each  event counters
- opcode_hit  out  32  bit i set when a 32-bit instruction with insn[6:2]==i retires
- c_quad_hit  out  3  bit q set when a compressed instruction with insn[1:0]==q retires
- mode_hit  out  4  bit m set when a sample is seen with mode==m
- xrd_hit, frd_hit  out  32 each  sticky OR of x_wb and f_wb
- csr_mstatus_hit  out  1  a CSR write to address 0x300 was seen
- order_err, pc_err, mode_err  out  1 each  sticky error flags

## Operation
Everything in this section happens only in a cycle where valid=1.
- **mode_hit:** mode_hit[mode] is set, trapped or not. mode==2 sets mode_err as well as mode_hit[2].
- **trap=1:**
  - trap_cnt increments.
  - intr_cnt also increments if any of the four interrupt inputs is 1.
  - No other counter or bitmap changes.
- **trap=0 and debug_mode=0:**
  - retired_cnt increments.
  - If insn[1:0]==2'b11, opcode_hit[insn[6:2]] is set; otherwise c_quad_hit[insn[1:0]] is set.
  - xrd_hit |= x_wb.
  - If csr_wb=1: csr_wr_cnt increments, and csr_mstatus_hit is set when csr_addr==12'h300.
- **trap=0 and debug_mode=1:** retired_cnt increments; opcode, register and CSR coverage is not updated.
- **Order check:**
  - The first valid sample after reset or clear only records order.
  - Every later valid sample with order != previous order + 1 (modulo 2^64) sets order_err.
  - Trapped samples take part in the order check.
- **PC check:** pc_rdata[0]==1 sets pc_err.
- **Counters:** all counters saturate at all-ones and never wrap.
- **Bitmaps and error flags:** sticky until reset or clear.

## Timing
- **Reset:** reset_n low asynchronously zeroes every output and the internal first-sample flag and previous-order register.
- **Latency:** all outputs are registered. The effect of a sample at edge N is visible after edge N.
- **clear=1:** at the edge, clear has the same effect as reset. A sample presented in the same cycle is discarded; clear wins.
- **valid=0:** no state changes; all other inputs are ignored.
- **Reset mid-trace:** the next valid sample is treated as the first sample and is not order-checked.

## Configuration
- **COVER_FP_EN defined:** frd_hit |= f_wb on each non-trapped, non-debug sample.
- **COVER_FP_EN undefined:** f_wb is ignored, and frd_hit is tied to 0 with no storage.

## Test plan
- Reset, then three valid samples with order 1, 2, 3, insn 0x00000013 and mode 3 -> retired_cnt=3, opcode_hit[4]=1, mode_hit=4'b1000, order_err=0.
- Sample with order 5 following order 3 -> order_err=1 one cycle later, and it stays set after further in-order samples.
- Sample with trap=1 and m_timer_intr=1 -> trap_cnt=1, intr_cnt=1, retired_cnt unchanged, opcode_hit unchanged.
- Sample with insn 0x00000001 (compressed) and x_wb=0x00000400 -> c_quad_hit[1]=1, xrd_hit bit 10 set; then a sample with csr_wb=1 and csr_addr=0x300 -> csr_wr_cnt=1, csr_mstatus_hit=1.
- pc_rdata=0x80000001 with mode=2 -> pc_err=1 and mode_err=1. Then clear=1 together with valid=1 -> all outputs 0 on the next cycle.
- COVER_FP_EN defined, f_wb=0x1 -> frd_hit=0x1. Same stimulus with the macro undefined -> frd_hit=0.
